// File: rtl/ram_bist_if.sv
// rtl/ram_bist_if.sv - RAM-side bus between the BIST controller and the distributed RAM
interface ram_bist_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] a;
   logic [DATA_W-1:0] d;
   logic              we;
   logic              qspo_ce;
   logic              qspo_srst;
   logic [DATA_W-1:0] qspo;

   modport master (output a, d, we, qspo_ce, qspo_srst, input qspo);
   modport slave  (input a, d, we, qspo_ce, qspo_srst, output qspo);
endinterface

// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - write/read-back self-test engine for a registered-output RAM
module ram_bist_ctrl #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              start_i,
   input  logic [DATA_W-1:0] seed_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [ADDR_W:0]   err_count_o,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [DATA_W-1:0] fail_data_o,
   ram_bist_if.master        ram
);

   typedef enum logic [2:0] {S_IDLE, S_CLR, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   ERR_ONE  = (ADDR_W + 1)'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] prev_q, prev_d;
   logic [DATA_W-1:0] seed_q, seed_d;
   logic [ADDR_W:0]   err_q, err_d;
   logic [ADDR_W-1:0] faddr_q, faddr_d;
   logic [DATA_W-1:0] fdata_q, fdata_d;

   logic              cmp_en;
   logic [DATA_W-1:0] cmp_exp;
   logic [ADDR_W-1:0] ram_a_c;
   logic [DATA_W-1:0] ram_d_c;
   logic              ram_we_c, ram_ce_c, ram_srst_c;

   function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                 input logic [ADDR_W-1:0] idx);
      return s ^ DATA_W'(idx);
   endfunction

   // Next-state, RAM control and compare logic; read data lags the issued address by one cycle
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      prev_d     = prev_q;
      seed_d     = seed_q;
      err_d      = err_q;
      faddr_d    = faddr_q;
      fdata_d    = fdata_q;
      cmp_en     = 1'b0;
      ram_a_c    = '0;
      ram_d_c    = '0;
      ram_we_c   = 1'b0;
      ram_ce_c   = 1'b0;
      ram_srst_c = 1'b0;
      cmp_exp    = pattern(seed_q, prev_q);
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               seed_d  = seed_i;
               err_d   = '0;
               faddr_d = '0;
               fdata_d = '0;
               state_d = S_CLR;
            end
         end
         S_CLR: begin
            ram_srst_c = 1'b1;
            cnt_d      = '0;
            state_d    = S_WRITE;
         end
         S_WRITE: begin
            ram_we_c = 1'b1;
            ram_a_c  = cnt_q;
            ram_d_c  = pattern(seed_q, cnt_q);
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_READ;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_READ: begin
            ram_ce_c = 1'b1;
            ram_a_c  = cnt_q;
            prev_d   = cnt_q;
            cmp_en   = (cnt_q != '0);
            if (cnt_q == CNT_LAST) state_d = S_DRAIN;
            else                   cnt_d   = cnt_q + CNT_ONE;
         end
         S_DRAIN: begin
            cmp_en  = 1'b1;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      if (cmp_en && (ram.qspo != cmp_exp)) begin
         if (err_q == '0) begin
            faddr_d = prev_q;
            fdata_d = ram.qspo;
         end
         err_d = err_q + ERR_ONE;
      end
   end

   // State and result registers with synchronous reset
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         prev_q  <= '0;
         seed_q  <= '0;
         err_q   <= '0;
         faddr_q <= '0;
         fdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prev_q  <= prev_d;
         seed_q  <= seed_d;
         err_q   <= err_d;
         faddr_q <= faddr_d;
         fdata_q <= fdata_d;
      end
   end

   assign busy_o        = (state_q == S_CLR) || (state_q == S_WRITE) ||
                          (state_q == S_READ) || (state_q == S_DRAIN);
   assign done_o        = (state_q == S_DONE);
   assign pass_o        = done_o && (err_q == '0);
   assign err_count_o   = err_q;
   assign fail_addr_o   = faddr_q;
   assign fail_data_o   = fdata_q;
   assign ram.a         = ram_a_c;
   assign ram.d         = ram_d_c;
   assign ram.we        = ram_we_c;
   assign ram.qspo_ce   = ram_ce_c;
   assign ram.qspo_srst = ram_srst_c;

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
Initiator-side controller for the synchronous distributed RAM (ports a, d, we, qspo_ce, qspo_srst, qspo). On a start pulse it writes a seed-derived pattern to every location, then reads every location back and compares against the expected pattern. The registered-output read latency is accounted for. The block reports pass/fail, the first failing address and data, and an error count. It sits beside the RAM as a power-on/diagnostic self-test engine and owns all RAM control inputs while busy.

Parameters:
ADDR_W, 6, RAM address width (drives ram_a).
DATA_W, 32, RAM data width.
DEPTH, 32, number of locations tested, addresses 0..DEPTH-1; DEPTH <= 2**ADDR_W.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
srst  input  1  synchronous reset, active-high.
start  input  1  one-cycle request to begin a test; ignored unless idle or done.
seed  input  DATA_W  pattern seed, sampled when start is accepted.
busy  output  1  high while a test is in progress.
done  output  1  high from test completion until the next accepted start or srst.
pass  output  1  valid while done=1; 1 = zero mismatches.
err_count  output  ADDR_W+1  number of mismatching locations in the last test.
fail_addr  output  ADDR_W  address of the first mismatch (0 if none).
fail_data  output  DATA_W  qspo value read at the first mismatch (0 if none).
ram_a  output  ADDR_W  RAM address.
ram_d  output  DATA_W  RAM write data.
ram_we  output  1  RAM write enable.
ram_qspo_ce  output  1  RAM output-register enable.
ram_qspo_srst  output  1  RAM output-register synchronous reset.
ram_qspo  input  DATA_W  RAM registered read data.

Behaviour:
- Reset: srst takes priority over start. State becomes IDLE. All outputs are 0: busy, done, pass, err_count, fail_addr, fail_data, ram_a, ram_d, ram_we, ram_qspo_ce, ram_qspo_srst.
- Reset mid-test: aborts on the next edge. ram_we is deasserted the cycle after srst is sampled. The RAM contents are left as partially written.
- Expected pattern: exp(i) = seed_reg XOR zero-extend(i).
- RAM model: qspo <= mem[a] on an edge where qspo_ce=1; qspo <= 0 on an edge where qspo_srst=1; otherwise qspo holds. All outputs are registered.
- States: IDLE, CLR, WRITE, READ, DRAIN, DONE.
  - IDLE/DONE + start: capture seed, clear err_count/fail_addr/fail_data/pass/done, go to CLR, busy=1.
  - CLR (1 cycle): ram_qspo_srst=1, ram_we=0, ram_qspo_ce=0. Go to WRITE with address counter=0.
  - WRITE (DEPTH cycles): ram_we=1, ram_a=i, ram_d=exp(i), ram_qspo_ce=0. After i=DEPTH-1, go to READ with counter=0.
  - READ (DEPTH cycles): ram_we=0, ram_qspo_ce=1, ram_a=i. A compare pipeline register holds the previous issued address. In each READ cycle except the first, ram_qspo is compared with exp(prev).
  - DRAIN (1 cycle): ram_qspo_ce=0. Compare the last address, DEPTH-1.
  - DONE: busy=0, done=1, pass=(err_count==0). RAM control outputs are 0. Stay in DONE until start or srst.
- Compare: on a mismatch, err_count increments. On the first mismatch only, fail_addr and fail_data are latched. err_count cannot overflow, because DEPTH <= 2**ADDR_W.
- Timing: start sampled at the edge ending cycle T.
  - CLR: cycle T+1.
  - WRITE: cycles T+2 .. T+DEPTH+1.
  - READ: cycles T+DEPTH+2 .. T+2*DEPTH+1.
  - DRAIN: cycle T+2*DEPTH+2.
  - done=1 from cycle T+2*DEPTH+3 (T+67 for DEPTH=32).
- start while busy: ignored. It has no effect on state or seed.
- start in DONE: begins a new test. Results from the previous test clear at the CLR entry edge.

Test Plan:
- Good RAM, seed=32'hA5A5_0000, start one cycle → ram_we high exactly 32 cycles with ram_d=32'hA5A5_0000..32'hA5A5_001F; done at T+67; pass=1, err_count=0, fail_addr=0, fail_data=0.
- Fault model forcing qspo bit 3 to 0 at address 5, seed=32'h0000_0008 → pass=0, err_count=1, fail_addr=5, fail_data=32'h0000_0005.
- Fault forcing qspo bit 0 stuck at 1 on all reads, seed=0 → err_count=16 (all even addresses), fail_addr=0, fail_data=32'h1.
- srst asserted during WRITE at address 10 → next cycle ram_we=0, busy=0, state IDLE; a subsequent start runs a full test and passes.
- start re-pulsed during READ with seed=32'hFFFF_FFFF → ignored; results still match the original seed; done at T+67.
- Back-to-back: after a failing run, start with the fault removed → err_count cleared at CLR, final pass=1.
